// File: rtl/sync_ram_hs_if.sv
// rtl/sync_ram_hs_if.sv - request/response bus for the handshaked synchronous RAM
interface sync_ram_hs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                    req;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, write, addr, wdata, be,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, write, addr, wdata, be,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/sync_ram_hs.sv
// rtl/sync_ram_hs.sv - single-port byte-enabled RAM with req/busy/done handshake and configurable read latency
module sync_ram_hs #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter int                    RD_LAT     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '1
) (
    input logic         clk,
    input logic         clr,
    sync_ram_hs_if.slave bus
);
    localparam int                  NB      = DATA_WIDTH / 8;
    localparam int                  IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                state;
    logic [1:0]            cnt;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rd_buf;

    // Power-up content only; clr never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};

    logic          in_range;
    logic [IW-1:0] idx;
    logic          accept;

    assign in_range = ({1'b0, bus.addr} < DEPTH_W);
    assign idx      = bus.addr[IW-1:0];
    assign accept   = !clr && (state == IDLE) && bus.req;

    always_ff @(posedge clk) begin
        if (accept && bus.write && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // READ holds the RD_LAT-1 extra cycles; DONE is the single done cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    if (bus.req) begin
                        if (!in_range) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (bus.write) begin
                            state <= DONE;
                        end else if (RD_LAT == 1) begin
                            rdata_q <= mem[idx];
                            state   <= DONE;
                        end else begin
                            rd_buf <= mem[idx];
                            cnt    <= 2'(RD_LAT - 2);
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    err_q <= 1'b0;
                    if (cnt == 2'd0) begin
                        rdata_q <= rd_buf;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: doc/sync_ram_hs.md
SYNC_RAM_HS -- requirements
Module: sync_ram_hs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, number of implemented words; range 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; range 1..4.
REQ-005 SHALL have parameter INIT_VAL, default all-ones, power-up content of every word.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port req, input, 1 bit: operation request, sampled only in IDLE.
REQ-009 SHALL have port write, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-010 SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-011 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port be, input, DATA_WIDTH/8 bits: byte enables; bit i qualifies wdata[8i+7:8i].
REQ-013 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1 bit: valid with done; high means addr >= DEPTH.
REQ-016 SHALL have port rdata, output, DATA_WIDTH bits: read result, held between reads.

Function
REQ-017 SHALL implement FSM states IDLE, READ (latency count), DONE; busy = (state != IDLE).
REQ-018 SHALL, in IDLE at edge E0 with req=1, capture write, addr, wdata and be and leave IDLE.
REQ-019 SHALL, for a write with addr < DEPTH, update at E0 only the bytes whose be bit is 1, then enter DONE.
REQ-020 SHALL, for a read with addr < DEPTH, read the array at E0, enter READ, and load rdata at edge E_RD_LAT, entering DONE at that same edge.
REQ-021 SHALL, for RD_LAT=1, go directly from IDLE to DONE at E0 with rdata loaded at E1 timing equal to done; i.e. done and new rdata both become visible after edge E_L, with L=1 for writes and L=RD_LAT for reads.
REQ-022 SHALL hold done=1 for exactly one cycle, in DONE, then return to IDLE at the next edge.
REQ-023 SHALL accept the next req no earlier than the edge after done falls; a req while busy is ignored, not queued.
REQ-024 SHALL, for addr >= DEPTH, perform no array access, leave rdata unchanged, and complete with L=1, done=1, err=1.
REQ-025 SHALL drive err=0 whenever done=0.
REQ-026 SHALL, for a write with be all zero, leave memory unchanged and still pulse done with err=0.
REQ-027 SHALL return, on a read, data written by any previously completed write to that address.
REQ-028 SHALL leave rdata unchanged on writes and on erroring operations.
REQ-029 SHALL initialise every word to INIT_VAL at power-up only.

Reset
REQ-030 SHALL, on clr=1 at a rising edge, force state IDLE, busy=0, done=0, err=0, rdata=0.
REQ-031 SHALL NOT modify memory contents on clr.
REQ-032 SHALL give clr priority over req at the same edge; that req is dropped.
REQ-033 SHALL, on clr mid-operation, keep a write already committed at E0, discard an in-flight read, and produce no done.

Verification
REQ-034 Bench SHALL cover: write addr 5, wdata 0x12345678, be 4'b1111; then read addr 5 with RD_LAT=3 -> done 3 cycles after the read is sampled, rdata=0x12345678, err=0.
REQ-035 Bench SHALL cover: from power-up, write addr 7, wdata 0xAABBCCDD, be 4'b0101 -> read addr 7 returns 0xFFBBFFDD.
REQ-036 Bench SHALL cover: DEPTH=256, read addr 300 -> done 1 cycle later with err=1 and rdata unchanged.
REQ-037 Bench SHALL cover: req held high through a whole operation -> exactly one done per accepted op, with no acceptance while busy=1.
REQ-038 Bench SHALL cover: clr asserted during the READ state (RD_LAT=4) -> no done, rdata=0, busy=0 next cycle, and memory intact on re-read.
REQ-039 Bench SHALL cover: clr and req high at the same edge -> request ignored, state IDLE.
